// File: rtl/mem_stage.sv
// Memory stage: issues LW/SW to a variable-latency en/valid data memory and selects the writeback value.
// Latency: non-memory ops and misaligned accesses pass through in 0 cycles; aligned accesses stall 2 + memory wait cycles.
// Backpressure: stall freezes upstream stages from detection until the DONE cycle; a missing response aborts after TIMEOUT cycles.
module mem_stage #(
  // Cycles to wait for mem_valid after mem_en before aborting (2..255)
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluout,
  input  logic [15:0] SrcData2,
  input  logic        memread,
  input  logic        memwrite,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic [15:0] wbdata,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value at which an unanswered request is abandoned
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] load_q;
  logic [7:0]  cnt;

  logic access;
  logic accept;

  // Both strobes high is treated as a store since mem_wr follows memwrite
  assign access = memread | memwrite;

  // The response is only honoured after the request cycle, never alongside mem_en
  assign accept = (state == WAIT) & ~mem_en & mem_valid;

  // Access sequencer: request issue, response wait with timeout, one-cycle completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      load_q    <= 16'h0000;
      cnt       <= 8'd0;
      err       <= 1'b0;
    end else begin
      // Strobes default low so each is a single-cycle pulse
      mem_en <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (aluout[0]) begin
              // Halfword access to an odd address: flag it, never touch memory
              err <= 1'b1;
            end else begin
              mem_addr  <= aluout;
              mem_wdata <= SrcData2;
              mem_wr    <= memwrite;
              mem_en    <= 1'b1;
              cnt       <= 8'd0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (accept) begin
            if (!mem_wr) begin
              load_q <= mem_rdata;
            end
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            // Abandon the access; a load returns zero and the error is seen in DONE
            load_q <= 16'h0000;
            err    <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          // Inputs still carry the completed instruction, so never restart here
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall and writeback selection from current state and the instruction on the inputs
  always_comb begin
    stall  = 1'b0;
    wbdata = aluout;
    case (state)
      IDLE: begin
        if (access) begin
          if (aluout[0]) begin
            wbdata = 16'h0000;
          end else begin
            stall = 1'b1;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
      end
      DONE: begin
        if (!mem_wr) begin
          wbdata = load_q;
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scoreboarded LW/SW/ALU instructions against a behavioural memory responder.
// Latency: each instruction is tracked from drive until the stall drops, plus an optional trailing idle cycle.
// Backpressure: the bench holds the instruction on the inputs for as long as stall is high.
module tb_mem_stage;

  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic [15:0] aluout;
  logic [15:0] SrcData2;
  logic        memread;
  logic        memwrite;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] wbdata;
  logic        stall;
  logic        err;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] wb;
    int          stall_n;
    int          err_n;
    int          en_n;
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
  } exp_t;

  exp_t sb_q[$];

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .aluout   (aluout),
    .SrcData2 (SrcData2),
    .memread  (memread),
    .memwrite (memwrite),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .wbdata   (wbdata),
    .stall    (stall),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, answer its memory request after 'delay' cycles (0 = never),
  // and score the observed behaviour against the expectation pushed at drive time.
  task automatic run_instr(input string tag, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] data,
                           input int delay, input logic [15:0] rdata,
                           input bit early, input bit trail);
    exp_t        e;
    exp_t        got;
    int          cyc;
    int          en_at;
    int          stall_n;
    int          err_n;
    int          en_n;
    bit          done;
    bit          access;
    bit          aligned;
    bit          timed_out;
    logic [15:0] wb_obs;
    logic [15:0] a_obs;
    logic [15:0] d_obs;
    logic        wr_obs;

    access    = rd | wr;
    aligned   = access && !addr[0];
    timed_out = aligned && (delay == 0);

    if (!access)         e.wb = addr;
    else if (!aligned)   e.wb = 16'h0000;
    else if (wr)         e.wb = addr;
    else if (timed_out)  e.wb = 16'h0000;
    else                 e.wb = rdata;
    e.stall_n = !aligned ? 0 : (timed_out ? 1 + TMO : 2 + delay);
    e.err_n   = ((access && !aligned) || timed_out) ? 1 : 0;
    e.en_n    = aligned ? 1 : 0;
    e.addr    = addr;
    e.wr      = wr;
    e.wdata   = data;
    sb_q.push_back(e);

    aluout   = addr;
    SrcData2 = data;
    memread  = rd;
    memwrite = wr;

    cyc = 0; en_at = -1; stall_n = 0; err_n = 0; en_n = 0; done = 1'b0;
    wb_obs = 16'h0; a_obs = 16'h0; d_obs = 16'h0; wr_obs = 1'b0;

    while (!done && cyc < 200) begin
      @(negedge clk);
      if (err) err_n++;
      if (mem_en) begin
        en_n++;
        en_at  = cyc;
        a_obs  = mem_addr;
        d_obs  = mem_wdata;
        wr_obs = mem_wr;
        if (early) begin
          // Response in the request cycle itself must be ignored
          mem_valid = 1'b1;
          mem_rdata = 16'h0BAD;
        end
      end
      if (stall) stall_n++;
      else begin
        done   = 1'b1;
        wb_obs = wbdata;
      end
      @(posedge clk); #1;
      cyc++;
      mem_valid = 1'b0;
      mem_rdata = 16'hDEAD;
      if (!done && en_at >= 0 && delay > 0 && cyc == en_at + delay) begin
        mem_valid = 1'b1;
        mem_rdata = rdata;
      end
    end
    check({tag, ".completed"}, 32'(done), 32'd1);

    if (trail) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      aluout   = 16'h7777;
      @(negedge clk);
      if (err) err_n++;
      if (mem_en) en_n++;
      check({tag, ".trail_stall"}, 32'(stall), 32'd0);
      @(posedge clk); #1;
    end

    got = sb_q.pop_front();
    check({tag, ".wbdata"}, 32'(wb_obs), 32'(got.wb));
    check({tag, ".stall_cycles"}, stall_n, got.stall_n);
    check({tag, ".en_count"}, en_n, got.en_n);
    if (trail) check({tag, ".err_count"}, err_n, got.err_n);
    if (got.en_n == 1) begin
      check({tag, ".en_cycle"}, en_at, 32'd1);
      check({tag, ".mem_addr"}, 32'(a_obs), 32'(got.addr));
      check({tag, ".mem_wr"}, 32'(wr_obs), 32'(got.wr));
      if (got.wr) check({tag, ".mem_wdata"}, 32'(d_obs), 32'(got.wdata));
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    aluout    = 16'h0005;
    SrcData2  = 16'h0000;
    memread   = 1'b0;
    memwrite  = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = 16'hDEAD;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.mem_en", 32'(mem_en), 32'd0);
    check("rst.mem_wr", 32'(mem_wr), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check("rst.mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.wbdata", 32'(wbdata), 32'h0005);
    @(posedge clk); #1;

    // ALU pass-through, plain LW/SW, early stray response, misaligned, store-wins
    run_instr("alu",      1'b0, 1'b0, 16'h1234, 16'h0000, 0, 16'h0000, 1'b0, 1'b1);
    run_instr("lw",       1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF, 1'b0, 1'b1);
    run_instr("sw",       1'b0, 1'b1, 16'h0042, 16'h00A5, 4, 16'h0000, 1'b0, 1'b1);
    run_instr("lw_early", 1'b1, 1'b0, 16'h0100, 16'h0000, 2, 16'h5A5A, 1'b1, 1'b1);
    run_instr("lw_odd",   1'b1, 1'b0, 16'h0041, 16'h0000, 0, 16'h0000, 1'b0, 1'b1);
    run_instr("sw_odd",   1'b0, 1'b1, 16'h0043, 16'h1111, 0, 16'h0000, 1'b0, 1'b1);
    run_instr("rdwr",     1'b1, 1'b1, 16'h0060, 16'hC3C3, 1, 16'h9999, 1'b0, 1'b1);

    // Response on the last counter value still wins over the abort
    run_instr("lw_last",  1'b1, 1'b0, 16'h0080, 16'h0000, TMO - 1, 16'h7E57, 1'b0, 1'b1);

    // Timeout, then a late response while idle
    run_instr("lw_tmo",   1'b1, 1'b0, 16'h0090, 16'h0000, 0, 16'h0000, 1'b0, 1'b1);
    mem_valid = 1'b1;
    mem_rdata = 16'hABCD;
    @(negedge clk);
    check("late_valid.stall", 32'(stall), 32'd0);
    check("late_valid.wbdata", 32'(wbdata), 32'h7777);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("late_valid.mem_en", 32'(mem_en), 32'd0);
    check("late_valid.stall_after", 32'(stall), 32'd0);
    @(posedge clk); #1;

    // Back-to-back accesses: the second starts right after DONE
    run_instr("b2b_sw",   1'b0, 1'b1, 16'h0200, 16'h4321, 2, 16'h0000, 1'b0, 1'b0);
    run_instr("b2b_lw",   1'b1, 1'b0, 16'h0200, 16'h0000, 1, 16'h4321, 1'b0, 1'b1);

    // Reset while an LW waits, with a stray response arriving in IDLE
    aluout   = 16'h0040;
    memread  = 1'b1;
    memwrite = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort.mem_en", 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    rst      = 1'b1;
    memread  = 1'b0;
    aluout   = 16'h0011;
    @(posedge clk); #1;
    rst       = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 16'hCAFE;
    @(negedge clk);
    check("abort.stall", 32'(stall), 32'd0);
    check("abort.mem_en_after", 32'(mem_en), 32'd0);
    check("abort.err", 32'(err), 32'd0);
    check("abort.mem_addr", 32'(mem_addr), 32'd0);
    check("abort.wbdata", 32'(wbdata), 32'h0011);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("abort.stray_stall", 32'(stall), 32'd0);
    check("abort.stray_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    run_instr("lw_post_rst", 1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF, 1'b0, 1'b1);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage directly downstream of EX: consumes the EX ALU result as a byte address and the second source operand as store data.
- Performs LW/SW through a variable-latency en/valid data-memory handshake, stalling the pipeline until the access completes.
- Presents the writeback value: load data for loads, the ALU result otherwise.
- Pure pass-through (0 cycles, no stall) for non-memory instructions.

Parameters:
TIMEOUT, 64, max cycles to wait for mem_valid after mem_en before aborting the access (range 2..255).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
aluout  input  16  EX result; memory byte address for LW/SW
SrcData2  input  16  store data for SW
memread  input  1  current instruction is LW
memwrite  input  1  current instruction is SW
mem_addr  output  16  registered address to data memory
mem_wdata  output  16  registered store data
mem_en  output  1  one-cycle request strobe (registered)
mem_wr  output  1  1 = write, 0 = read; valid while mem_en=1
mem_rdata  input  16  read data from memory, valid with mem_valid
mem_valid  input  1  memory completion pulse
wbdata  output  16  value for writeback stage
stall  output  1  freeze PC/IF/ID/EX and hold their outputs
err  output  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset (synchronous, rst=1 at a clock edge) sets the following state:
  - state=IDLE; mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - load register=0, timeout counter=0, err=0.
  - rst overrides any in-flight access; a later mem_valid arriving in IDLE is ignored.
- FSM states: IDLE, WAIT, DONE.
- access = memread | memwrite. If both are high, the instruction is treated as a write.
- IDLE:
  - access=0: wbdata=aluout combinationally, stall=0, stay in IDLE.
  - access=1 and aluout[0]=1 (misaligned):
    - No memory request is issued; stall=0.
    - err=1 on the next cycle for one cycle.
    - wbdata=16'h0000 in the current cycle; stay in IDLE.
  - access=1 and aligned:
    - stall=1 combinationally.
    - At the edge: capture mem_addr=aluout, mem_wdata=SrcData2, mem_wr=memwrite; set mem_en=1; clear the counter; go to WAIT.
- WAIT:
  - stall=1 throughout.
  - mem_en=1 only in the first WAIT cycle.
  - mem_valid is ignored in the cycle mem_en=1; the earliest accepted mem_valid is the following cycle.
  - On an accepted mem_valid: capture mem_rdata into the load register if mem_wr=0; go to DONE.
  - Otherwise the counter increments each cycle.
  - When counter reaches TIMEOUT-1 without mem_valid: load register=0; err=1 for one cycle (the DONE cycle); go to DONE.
- DONE:
  - stall=0 for exactly one cycle.
  - wbdata = load register if the access was a read, else aluout.
  - The inputs still show the same instruction (held by the stall); they must NOT start a new access.
  - Unconditional return to IDLE.
- Latency: read with mem_valid 1 cycle after mem_en gives stall high 3 cycles (IDLE detect, WAIT-en, WAIT-valid), then DONE. Each extra memory wait cycle adds one stall cycle.
- Back-to-back memory instructions: the second starts in the IDLE cycle after DONE; there are no dead cycles beyond DONE.
- mem_valid outside WAIT is ignored. mem_addr/mem_wdata/mem_wr hold their values until the next request.

Test Plan:
- ALU op pass-through: memread=memwrite=0, aluout=16'h1234 -> wbdata=16'h1234 same cycle, stall=0, mem_en never asserted.
- LW at 16'h0040, mem returns 16'hBEEF one cycle after mem_en -> mem_en one pulse with mem_addr=16'h0040 and mem_wr=0; stall high 3 cycles; DONE cycle wbdata=16'hBEEF, stall=0; IDLE next.
- SW at 16'h0042, data 16'h00A5, mem_valid 4 cycles after mem_en -> mem_wr=1, mem_wdata=16'h00A5, stall high 6 cycles, wbdata=16'h0042 in DONE; stall and en never re-triggered.
- Misaligned LW at 16'h0041 -> no mem_en, stall=0, wbdata=0, err pulses 1 cycle.
- Timeout with TIMEOUT=8, mem_valid never asserted -> DONE reached 8 cycles after the en cycle, err=1 that cycle, wbdata=0; a mem_valid arriving later in IDLE is ignored.
- rst=1 during WAIT of an LW -> next cycle IDLE, stall=0, mem_en=0, err=0; a subsequent LW behaves as in the second scenario.
